// File: rtl/fpga_boot_sequencer.sv
// ---------------------------------------------------------------------------
// fpga_boot_sequencer
//
// Brings an MCU system out of reset after the clock wizard locks. The strap
// pins are debounced and latched, the system reset is held for a fixed number
// of cycles, and the MCU then runs until it reports an exit value. That value
// is captured and shown on the status LEDs. Losing PLL lock at any point
// puts the system back into reset and restarts the sequence.
//
// Ports
//   clk_gen               system clock from the clock wizard
//   rst_n                 asynchronous active-low reset
//   pll_locked_i          clock-wizard lock (asynchronous, synchronized here)
//   boot_select_pad_i     raw strap pin (asynchronous, may bounce)
//   exec_flash_pad_i      raw strap pin (asynchronous, may bounce)
//   exit_valid_i          system exit-valid flag (clk_gen domain)
//   exit_value_i [31:0]   system exit value (clk_gen domain)
//   sys_rst_no            registered active-low reset to the MCU system
//   boot_select_o         latched boot_select strap
//   execute_from_flash_o  latched exec_flash strap
//   exit_value_o [31:0]   captured exit value
//   done_led_o            high while in DONE
//   pass_led_o            high while in DONE with a zero exit value
//   state_o [2:0]         current FSM state, for debug
// ---------------------------------------------------------------------------
module fpga_boot_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES = 256
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        pll_locked_i,
    input  logic        boot_select_pad_i,
    input  logic        exec_flash_pad_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        sys_rst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic [31:0] exit_value_o,
    output logic        done_led_o,
    output logic        pass_led_o,
    output logic [2:0]  state_o
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] DEBOUNCE  = 3'd1;
    localparam logic [2:0] HOLD      = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    // One spare count of headroom so each counter holds its terminal value.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD_CYCLES);

    // Two-flop synchronizers for the asynchronous inputs.
    logic lock_meta, lock_s;
    logic bs_meta, bs_s;
    logic ef_meta, ef_s;

    // Previous-cycle synchronized straps, used to detect bounce.
    logic [1:0] straps_prev;

    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        strap_change;
    logic        latch_straps;
    logic        capture;
    logic [31:0] exit_next;

    assign strap_change = ({bs_s, ef_s} != straps_prev);
    assign state_o      = state;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        latch_straps = 1'b0;
        capture      = 1'b0;
        // Lock loss overrides every other transition, including a same-cycle exit.
        if (state != WAIT_LOCK && !lock_s) begin
            next_state = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (lock_s) next_state = DEBOUNCE;
                DEBOUNCE: begin
                    if (!strap_change && db_cnt == DB_LAST) begin
                        next_state   = HOLD;
                        latch_straps = 1'b1;
                    end
                end
                HOLD:      if (hold_cnt == HOLD_LAST) next_state = RUN;
                RUN: begin
                    if (exit_valid_i) begin
                        next_state = DONE;
                        capture    = 1'b1;
                    end
                end
                DONE:      next_state = DONE;
                default:   next_state = WAIT_LOCK;
            endcase
        end
        exit_next = capture ? exit_value_i : exit_value_o;
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta            <= 1'b0;
            lock_s               <= 1'b0;
            bs_meta              <= 1'b0;
            bs_s                 <= 1'b0;
            ef_meta              <= 1'b0;
            ef_s                 <= 1'b0;
            straps_prev          <= 2'b00;
            db_cnt               <= '0;
            hold_cnt             <= '0;
            state                <= WAIT_LOCK;
            sys_rst_no           <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            exit_value_o         <= '0;
            done_led_o           <= 1'b0;
            pass_led_o           <= 1'b0;
        end else begin
            lock_meta   <= pll_locked_i;
            lock_s      <= lock_meta;
            bs_meta     <= boot_select_pad_i;
            bs_s        <= bs_meta;
            ef_meta     <= exec_flash_pad_i;
            ef_s        <= ef_meta;
            straps_prev <= {bs_s, ef_s};

            // Held at zero while waiting for lock, so DEBOUNCE always starts clean.
            if (state == WAIT_LOCK) begin
                db_cnt <= '0;
            end else if (state == DEBOUNCE) begin
                if (strap_change)          db_cnt <= '0;
                else if (db_cnt != DB_LAST) db_cnt <= db_cnt + 1'b1;
            end

            if (latch_straps) begin
                hold_cnt <= '0;
            end else if (state == HOLD && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (latch_straps) begin
                boot_select_o        <= bs_s;
                execute_from_flash_o <= ef_s;
            end

            state        <= next_state;
            exit_value_o <= exit_next;
            // Registered from the next state so the outputs line up with state_o.
            sys_rst_no   <= (next_state == RUN) || (next_state == DONE);
            done_led_o   <= (next_state == DONE);
            pass_led_o   <= (next_state == DONE) && (exit_next == 32'd0);
        end
    end

endmodule

// File: tb/tb_fpga_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpga_boot_sequencer
//
// Self-checking bench for fpga_boot_sequencer with DEBOUNCE_CYCLES=8 and
// RST_HOLD_CYCLES=4. Expected output vectors are queued with the edge number
// at which they must appear; a monitor compares them on the falling edge.
// Output vector layout: {state, sys_rst_no, boot_select, exec_flash,
// done_led, pass_led, exit_value[31:0]}.
// ---------------------------------------------------------------------------
module tb_fpga_boot_sequencer;

    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int HOLD = 4;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_DEB  = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic        clk_gen = 1'b0;
    bit          clk_run = 1'b1;
    logic        rst_n;
    logic        pll_locked_i;
    logic        boot_select_pad_i;
    logic        exec_flash_pad_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        sys_rst_no;
    logic        boot_select_o;
    logic        execute_from_flash_o;
    logic [31:0] exit_value_o;
    logic        done_led_o;
    logic        pass_led_o;
    logic [2:0]  state_o;

    fpga_boot_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(HOLD)
    ) dut (
        .clk_gen              (clk_gen),
        .rst_n                (rst_n),
        .pll_locked_i         (pll_locked_i),
        .boot_select_pad_i    (boot_select_pad_i),
        .exec_flash_pad_i     (exec_flash_pad_i),
        .exit_valid_i         (exit_valid_i),
        .exit_value_i         (exit_value_i),
        .sys_rst_no           (sys_rst_no),
        .boot_select_o        (boot_select_o),
        .execute_from_flash_o (execute_from_flash_o),
        .exit_value_o         (exit_value_o),
        .done_led_o           (done_led_o),
        .pass_led_o           (pass_led_o),
        .state_o              (state_o)
    );

    // Clock can be frozen to show the reset acts without any clock edge.
    always begin
        #5;
        if (clk_run) clk_gen = ~clk_gen;
    end

    int cyc = 0;
    always @(posedge clk_gen) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] ev(input logic [2:0] st, input logic r, input logic b,
                                       input logic e, input logic d, input logic p,
                                       input logic [31:0] x);
        return {st, r, b, e, d, p, x};
    endfunction

    function automatic logic [39:0] out_vec();
        return {state_o, sys_rst_no, boot_select_o, execute_from_flash_o,
                done_led_o, pass_led_o, exit_value_o};
    endfunction

    typedef struct {
        string       tag;
        int          edge_no;
        logic [39:0] vec;
    } sb_t;

    sb_t sb[$];

    // Keep the queue ordered by edge number.
    task automatic push(input string tag, input int e, input logic [39:0] v);
        sb_t it;
        int  i;
        it.tag     = tag;
        it.edge_no = e;
        it.vec     = v;
        i = sb.size();
        while (i > 0 && sb[i-1].edge_no > e) i--;
        sb.insert(i, it);
    endtask

    sb_t mon_item;
    always @(negedge clk_gen) begin
        while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
            mon_item = sb.pop_front();
            if (mon_item.edge_no != cyc) check({mon_item.tag, "_edge"}, 40'(cyc), 40'(mon_item.edge_no));
            else                         check(mon_item.tag, out_vec(), mon_item.vec);
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk_gen);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_gen);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 40'(sb.size()), 40'd0);
            sb.delete();
        end
    endtask

    // Boot expectations: lock first sampled at edge k, straps latched at edge
    // latch, then HOLD cycles of reset before RUN.
    task automatic expect_boot(input string tag, input int k, input int latch,
                               input logic obs, input logic oef, input logic nbs,
                               input logic nef, input logic [31:0] x, input bit to_run);
        push({tag, "_wait"},    k + 1,            ev(S_WAIT, 1'b0, obs, oef, 1'b0, 1'b0, x));
        push({tag, "_deb0"},    k + SYNC,         ev(S_DEB,  1'b0, obs, oef, 1'b0, 1'b0, x));
        push({tag, "_deb_end"}, latch - 1,        ev(S_DEB,  1'b0, obs, oef, 1'b0, 1'b0, x));
        push({tag, "_latch"},   latch,            ev(S_HOLD, 1'b0, nbs, nef, 1'b0, 1'b0, x));
        if (to_run) begin
            push({tag, "_hold_end"}, latch + HOLD - 1, ev(S_HOLD, 1'b0, nbs, nef, 1'b0, 1'b0, x));
            push({tag, "_run"},      latch + HOLD,     ev(S_RUN,  1'b1, nbs, nef, 1'b0, 1'b0, x));
        end
    endtask

    // Reset pulse with the clock frozen, checked twice while held low.
    task automatic pulse_reset(input string tag);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1 check({tag, "_now"}, out_vec(), 40'h0);
        #10 check({tag, "_held"}, out_vec(), 40'h0);
        rst_n = 1'b1;
        #3 clk_run = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    int k;
    int f;
    int latch;

    initial begin
        rst_n             = 1'b0;
        pll_locked_i      = 1'b0;
        boot_select_pad_i = 1'b1;
        exec_flash_pad_i  = 1'b0;
        exit_valid_i      = 1'b0;
        exit_value_i      = 32'd0;

        repeat (3) @(negedge clk_gen);
        check("reset", out_vec(), 40'h0);
        rst_n = 1'b1;

        // Clean boot: lock first sampled at edge 10.
        goto(9);
        pll_locked_i = 1'b1;
        k = cyc + 1;
        latch = k + SYNC + DB;
        expect_boot("boot1", k, latch, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        drain(200);

        // Strap changes after latching must not propagate.
        @(negedge clk_gen);
        boot_select_pad_i = 1'b0;
        exec_flash_pad_i  = 1'b1;
        push("strap_ignored", cyc + 6, ev(S_RUN, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        drain(200);

        // Exit with zero: pass.
        @(negedge clk_gen);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
        push("exit_pass", cyc + 1, ev(S_DONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0));
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        repeat (2) @(negedge clk_gen);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd7;
        push("done_sticky", cyc + 2, ev(S_DONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0));
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;
        drain(200);

        // Lock loss in DONE for 5 cycles, then a full re-sequence.
        @(negedge clk_gen);
        pll_locked_i = 1'b0;
        f = cyc + 1;
        push("loss_done_pre", f + 1, ev(S_DONE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0));
        push("loss_done",     f + 2, ev(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
        goto(f + 4);
        pll_locked_i = 1'b1;
        k = cyc + 1;
        latch = k + SYNC + DB;
        expect_boot("boot2", k, latch, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
        drain(200);

        // Exit with 5: fail, and a later zero exit is ignored.
        @(negedge clk_gen);
        exit_valid_i = 1'b1;
        exit_value_i = 32'h5;
        push("exit_fail", cyc + 1, ev(S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5));
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;
        repeat (2) @(negedge clk_gen);
        exit_valid_i = 1'b1;
        push("exit_frozen", cyc + 2, ev(S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5));
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        drain(200);

        // Lock loss in DONE, then relock with boot_select bouncing every 3 cycles.
        @(negedge clk_gen);
        pll_locked_i = 1'b0;
        f = cyc + 1;
        push("loss2_pre", f + 1, ev(S_DONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5));
        push("loss2",     f + 2, ev(S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5));
        goto(f + 4);
        pll_locked_i = 1'b1;
        k = cyc + 1;
        latch = k + 27 + SYNC + DB;
        expect_boot("bounce", k, latch, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            boot_select_pad_i = ~boot_select_pad_i;
            repeat (3) @(negedge clk_gen);
        end
        drain(200);

        // Lock loss in RUN coincident with exit_valid: no capture.
        @(negedge clk_gen);
        pll_locked_i      = 1'b0;
        boot_select_pad_i = 1'b1;
        exec_flash_pad_i  = 1'b1;
        f = cyc + 1;
        push("loss_run_pre", f + 1, ev(S_RUN,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5));
        push("loss_run",     f + 2, ev(S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5));
        push("loss_nocap",   f + 4, ev(S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5));
        goto(f + 1);
        exit_valid_i = 1'b1;
        exit_value_i = 32'h99;
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;
        goto(f + 4);
        pll_locked_i = 1'b1;
        k = cyc + 1;
        latch = k + SYNC + DB;
        expect_boot("boot4", k, latch, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5, 1'b0);
        drain(200);

        // Reset pulse mid-HOLD.
        pulse_reset("rst_hold");
        k = cyc + 1;
        latch = k + SYNC + DB;
        expect_boot("boot5", k, latch, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1);
        drain(200);

        @(negedge clk_gen);
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
        push("exit_pass2", cyc + 1, ev(S_DONE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0));
        @(negedge clk_gen);
        exit_valid_i = 1'b0;
        drain(200);

        // Reset pulse in DONE.
        @(negedge clk_gen);
        pulse_reset("rst_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
